// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe move scheduler.
// Cell indices run 0..8; any value above 8 names no cell.
package ttt_pkg;

  typedef enum logic [2:0] {
    WAIT_REQ     = 3'd0,
    VALIDATE     = 3'd1,
    COMMIT       = 3'd2,
    REJECT       = 3'd3,
    WAIT_RELEASE = 3'd4,
    HALT         = 3'd5
  } sched_state_t;

  typedef logic [3:0] cell_t;

  localparam logic [1:0] PLAYER1   = 2'b01;
  localparam logic [1:0] PLAYER2   = 2'b10;
  localparam int         NUM_CELLS = 9;

  // Out-of-range cells are rejected before occupancy is looked at.
  function automatic logic cell_rejected(input cell_t c, input logic [NUM_CELLS-1:0] occ);
    if (c >= cell_t'(NUM_CELLS)) return 1'b1;
    return occ[c];
  endfunction

  function automatic logic [1:0] player_code(input logic is_p2);
    return is_p2 ? PLAYER2 : PLAYER1;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every CLK_HZ/1000 clocks.
// The tick is high on the last count of each period.
module ms_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic MAX10_CLK1_50,
  input  logic rst,
  output logic tick_o
);

  localparam int DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/turn_scheduler.sv
// Arbitrates the single board write port between the two move sources,
// enforcing turn order, cell validity and the per-turn timeout.
module turn_scheduler
  import ttt_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TURN_TIMEOUT_MS = 10_000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       rst,
  input  logic       p1_req,
  input  logic [3:0] p1_cell,
  input  logic       p2_req,
  input  logic [3:0] p2_cell,
  input  logic [8:0] occ,
  input  logic       game_over,
  input  logic       new_game,
  output logic       p1_ack,
  output logic       p2_ack,
  output logic       p1_nak,
  output logic       p2_nak,
  output logic       wr_en,
  output logic [3:0] wr_cell,
  output logic [1:0] wr_player,
  output logic       turn,
  output logic       timeout_pulse,
  output logic [2:0] sched_state
);

  localparam bit TIMEOUT_EN = (TURN_TIMEOUT_MS > 0);
  localparam int TW         = (TURN_TIMEOUT_MS > 1) ? $clog2(TURN_TIMEOUT_MS) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TURN_TIMEOUT_MS > 0) ? TURN_TIMEOUT_MS - 1 : 0);

  logic ms_tick;

  ms_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_ms_tick (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .rst           (rst),
    .tick_o        (ms_tick)
  );

  sched_state_t  state_q, state_d;
  logic          turn_q, turn_d;
  logic [TW-1:0] timer_q, timer_d;
  cell_t         cell_q, cell_d;
  logic          mover_q, mover_d;   // 0 = P1 owns the move in flight, 1 = P2
  logic          p1_ack_q, p1_ack_d;
  logic          p2_ack_q, p2_ack_d;
  logic          p1_nak_q, p1_nak_d;
  logic          p2_nak_q, p2_nak_d;
  logic          wr_en_q, wr_en_d;
  cell_t         wr_cell_q, wr_cell_d;
  logic [1:0]    wr_player_q, wr_player_d;
  logic          tout_q, tout_d;

  logic  cur_req;
  cell_t cur_cell;
  logic  mover_req;

  assign cur_req   = turn_q  ? p2_req  : p1_req;
  assign cur_cell  = turn_q  ? p2_cell : p1_cell;
  assign mover_req = mover_q ? p2_req  : p1_req;

  always_comb begin
    state_d     = state_q;
    turn_d      = turn_q;
    timer_d     = timer_q;
    cell_d      = cell_q;
    mover_d     = mover_q;
    p1_ack_d    = p1_ack_q;
    p2_ack_d    = p2_ack_q;
    p1_nak_d    = p1_nak_q;
    p2_nak_d    = p2_nak_q;
    wr_en_d     = 1'b0;
    wr_cell_d   = wr_cell_q;
    wr_player_d = wr_player_q;
    tout_d      = 1'b0;

    if (new_game) begin
      // Abandons any move in flight, including a write about to be issued.
      state_d  = WAIT_REQ;
      turn_d   = 1'b0;
      timer_d  = '0;
      p1_ack_d = 1'b0;
      p2_ack_d = 1'b0;
      p1_nak_d = 1'b0;
      p2_nak_d = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_REQ: begin
          if (game_over) begin
            state_d = HALT;
          end else if (cur_req) begin
            // A request on the timeout tick takes precedence over the forfeit.
            cell_d  = cur_cell;
            mover_d = turn_q;
            state_d = VALIDATE;
          end else if (TIMEOUT_EN && ms_tick) begin
            if (timer_q == TIMER_LAST) begin
              tout_d  = 1'b1;
              turn_d  = ~turn_q;
              timer_d = '0;
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end
        VALIDATE: begin
          if (cell_rejected(cell_q, occ)) begin
            if (mover_q) p2_nak_d = 1'b1;
            else         p1_nak_d = 1'b1;
            state_d = REJECT;
          end else begin
            wr_en_d     = 1'b1;
            wr_cell_d   = cell_q;
            wr_player_d = player_code(mover_q);
            if (mover_q) p2_ack_d = 1'b1;
            else         p1_ack_d = 1'b1;
            state_d = COMMIT;
          end
        end
        COMMIT: begin
          turn_d  = ~turn_q;
          timer_d = '0;
          state_d = WAIT_RELEASE;
        end
        REJECT: begin
          state_d = WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (!mover_req) begin
            p1_ack_d = 1'b0;
            p2_ack_d = 1'b0;
            p1_nak_d = 1'b0;
            p2_nak_d = 1'b0;
            state_d  = game_over ? HALT : WAIT_REQ;
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = WAIT_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) begin
      state_q     <= WAIT_REQ;
      turn_q      <= 1'b0;
      timer_q     <= '0;
      cell_q      <= '0;
      mover_q     <= 1'b0;
      p1_ack_q    <= 1'b0;
      p2_ack_q    <= 1'b0;
      p1_nak_q    <= 1'b0;
      p2_nak_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_cell_q   <= '0;
      wr_player_q <= 2'b00;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      turn_q      <= turn_d;
      timer_q     <= timer_d;
      cell_q      <= cell_d;
      mover_q     <= mover_d;
      p1_ack_q    <= p1_ack_d;
      p2_ack_q    <= p2_ack_d;
      p1_nak_q    <= p1_nak_d;
      p2_nak_q    <= p2_nak_d;
      wr_en_q     <= wr_en_d;
      wr_cell_q   <= wr_cell_d;
      wr_player_q <= wr_player_d;
      tout_q      <= tout_d;
    end
  end

  assign p1_ack        = p1_ack_q;
  assign p2_ack        = p2_ack_q;
  assign p1_nak        = p1_nak_q;
  assign p2_nak        = p2_nak_q;
  assign wr_en         = wr_en_q;
  assign wr_cell       = wr_cell_q;
  assign wr_player     = wr_player_q;
  assign turn          = turn_q;
  assign timeout_pulse = tout_q;
  assign sched_state   = state_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Random two-player bench for turn_scheduler against a turn-level reference model.
module tb_turn_scheduler;
  import ttt_pkg::*;

  localparam int CLK_HZ = 8000;
  localparam int TO_MS  = 3;
  localparam int DIV    = CLK_HZ / 1000;

  localparam int PH_IDLE    = 0;
  localparam int PH_CHECK   = 1;
  localparam int PH_COMMIT  = 2;
  localparam int PH_REJECT  = 3;
  localparam int PH_RELEASE = 4;
  localparam int PH_HALT    = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_a [2];
  logic [3:0] cell_a [2];
  logic [8:0] occ;
  logic       game_over;
  logic       new_game;

  logic       p1_ack, p2_ack, p1_nak, p2_nak;
  logic       wr_en;
  logic [3:0] wr_cell;
  logic [1:0] wr_player;
  logic       turn;
  logic       timeout_pulse;
  logic [2:0] sched_state;

  turn_scheduler #(
    .CLK_HZ          (CLK_HZ),
    .TURN_TIMEOUT_MS (TO_MS)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .rst           (rst),
    .p1_req        (req_a[0]),
    .p1_cell       (cell_a[0]),
    .p2_req        (req_a[1]),
    .p2_cell       (cell_a[1]),
    .occ           (occ),
    .game_over     (game_over),
    .new_game      (new_game),
    .p1_ack        (p1_ack),
    .p2_ack        (p2_ack),
    .p1_nak        (p1_nak),
    .p2_nak        (p2_nak),
    .wr_en         (wr_en),
    .wr_cell       (wr_cell),
    .wr_player     (wr_player),
    .turn          (turn),
    .timeout_pulse (timeout_pulse),
    .sched_state   (sched_state)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: whose turn it is, elapsed ms, and the move in flight.
  int         m_phase = PH_IDLE;
  int         m_ms    = 0;
  int         m_pre   = 0;
  logic       m_turn  = 1'b0;
  logic       m_mover = 1'b0;
  logic [3:0] m_cell  = 4'd0;
  logic       m_wr    = 1'b0;
  logic       m_tp    = 1'b0;
  logic [3:0] m_wcell = 4'd0;
  logic [1:0] m_wplayer = 2'b00;
  logic       m_ack [2] = '{1'b0, 1'b0};
  logic       m_nak [2] = '{1'b0, 1'b0};
  logic [8:0] m_board = 9'd0;
  logic       was_reset = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic tick;
    tick      = (m_pre == DIV - 1);
    m_wr      = 1'b0;
    m_tp      = 1'b0;
    was_reset = 1'b0;
    if (!rst) begin
      m_phase = PH_IDLE; m_turn = 1'b0; m_ms = 0; m_pre = 0;
      m_ack = '{1'b0, 1'b0}; m_nak = '{1'b0, 1'b0};
      m_wcell = 4'd0; m_wplayer = 2'b00; m_board = 9'd0;
      was_reset = 1'b1;
      return;
    end
    m_pre = tick ? 0 : m_pre + 1;
    if (new_game) begin
      m_phase = PH_IDLE; m_turn = 1'b0; m_ms = 0;
      m_ack = '{1'b0, 1'b0}; m_nak = '{1'b0, 1'b0};
      m_board = 9'd0;
      return;
    end
    case (m_phase)
      PH_IDLE: begin
        if (game_over) m_phase = PH_HALT;
        else if (req_a[m_turn]) begin
          m_cell = cell_a[m_turn]; m_mover = m_turn; m_phase = PH_CHECK;
        end else if (tick) begin
          m_ms++;
          if (m_ms == TO_MS) begin m_tp = 1'b1; m_turn = !m_turn; m_ms = 0; end
        end
      end
      PH_CHECK: begin
        if (m_cell > 4'd8 || occ[m_cell]) begin
          m_nak[m_mover] = 1'b1; m_phase = PH_REJECT;
        end else begin
          m_wr = 1'b1; m_wcell = m_cell;
          m_wplayer = m_mover ? 2'b10 : 2'b01;
          m_ack[m_mover] = 1'b1;
          m_board[m_cell] = 1'b1;
          m_phase = PH_COMMIT;
        end
      end
      PH_COMMIT: begin m_turn = !m_turn; m_ms = 0; m_phase = PH_RELEASE; end
      PH_REJECT: m_phase = PH_RELEASE;
      PH_RELEASE: begin
        if (!req_a[m_mover]) begin
          m_ack = '{1'b0, 1'b0}; m_nak = '{1'b0, 1'b0};
          m_phase = game_over ? PH_HALT : PH_IDLE;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check_eq("wr_en", wr_en, m_wr);
    if (m_wr) begin
      check_eq("wr_cell", wr_cell, m_wcell);
      check_eq("wr_player", wr_player, m_wplayer);
    end
    check_eq("p1_ack", p1_ack, m_ack[0]);
    check_eq("p2_ack", p2_ack, m_ack[1]);
    check_eq("p1_nak", p1_nak, m_nak[0]);
    check_eq("p2_nak", p2_nak, m_nak[1]);
    check_eq("turn", turn, m_turn);
    check_eq("timeout_pulse", timeout_pulse, m_tp);
    if (was_reset) begin
      check_eq("rst_wr_cell", wr_cell, 4'd0);
      check_eq("rst_wr_player", wr_player, 2'b00);
      check_eq("rst_state", sched_state, WAIT_REQ);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    occ = m_board;
  endtask

  task automatic drive_random();
    for (int p = 0; p < 2; p++) begin
      if (req_a[p] && (m_ack[p] || m_nak[p])) req_a[p] = 1'b0;
      else if (!req_a[p] && $urandom_range(0, 23) == 0) begin
        req_a[p]  = 1'b1;
        cell_a[p] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      end
    end
    new_game = ($urandom_range(0, 79) == 0);
    if (game_over) game_over = ($urandom_range(0, 7) != 0);
    else           game_over = ($urandom_range(0, 89) == 0);
    if (!rst) rst = ($urandom_range(0, 1) == 0);
    else      rst = ($urandom_range(0, 399) != 0);
  endtask

  initial begin
    req_a = '{1'b0, 1'b0};
    cell_a = '{4'd0, 4'd0};
    occ = 9'd0;
    game_over = 1'b0;
    new_game = 1'b0;

    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;

    // P1 opens on the centre cell.
    req_a[0] = 1'b1; cell_a[0] = 4'd4;
    step(); step();
    check_eq("dir_wr_en", wr_en, 1'b1);
    check_eq("dir_wr_cell", wr_cell, 4'd4);
    check_eq("dir_wr_player", wr_player, 2'b01);
    check_eq("dir_p1_ack", p1_ack, 1'b1);
    req_a[0] = 1'b0;
    step();
    check_eq("dir_turn_p2", turn, 1'b1);
    check_eq("dir_single_wr", wr_en, 1'b0);
    step();
    check_eq("dir_ack_clear", p1_ack, 1'b0);

    // Out-of-turn request from P1 must sit unanswered.
    req_a[0] = 1'b1; cell_a[0] = 4'd0;
    repeat (3) begin
      step();
      check_eq("dir_p1_ignored", {p1_ack, p1_nak, wr_en}, 3'b000);
    end

    // P2 aims at the occupied centre.
    req_a[1] = 1'b1; cell_a[1] = 4'd4;
    step(); step();
    check_eq("dir_p2_nak", p2_nak, 1'b1);
    check_eq("dir_nak_no_wr", wr_en, 1'b0);
    repeat (2) step();
    check_eq("dir_nak_held", p2_nak, 1'b1);
    req_a[1] = 1'b0;
    step();
    check_eq("dir_nak_clear", p2_nak, 1'b0);
    check_eq("dir_turn_kept", turn, 1'b1);

    // P2 plays cell 9: out of range.
    req_a[1] = 1'b1; cell_a[1] = 4'd9;
    step(); step();
    check_eq("dir_p2_nak_range", p2_nak, 1'b1);
    req_a[1] = 1'b0;
    step(); step();

    // P2 commits cell 0.
    req_a[1] = 1'b1; cell_a[1] = 4'd0;
    step(); step();
    check_eq("dir_p2_wr_player", wr_player, 2'b10);
    check_eq("dir_p2_ack", p2_ack, 1'b1);
    req_a[1] = 1'b0;
    step(); step();

    // Reset arriving while a write is on the port.
    req_a[0] = 1'b0;
    req_a[m_turn] = 1'b1; cell_a[m_turn] = 4'd8;
    step(); step();
    rst = 1'b0;
    step();
    check_eq("dir_rst_wr_en", wr_en, 1'b0);
    check_eq("dir_rst_turn", turn, 1'b0);
    check_eq("dir_rst_acks", {p1_ack, p2_ack, p1_nak, p2_nak}, 4'b0000);
    req_a = '{1'b0, 1'b0};
    rst = 1'b1;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      drive_random();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
